// File: rtl/shift_sequencer.sv
// Multicycle shifter (SLL/SRL/SRA/ROTL): iterates a shift-by-2 stage, with a
// final shift-by-1 for odd amounts, under a three-process IDLE/SHIFT/DONE FSM.
module shift_sequencer #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   out_data
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   step1, step2;
  logic               use2;

  // Both step widths are built every cycle; cnt picks which one is committed.
  always_comb begin
    unique case (op_q)
      OP_SLL: begin
        step1 = {acc_q[WIDTH-2:0], 1'b0};
        step2 = {acc_q[WIDTH-3:0], 2'b00};
      end
      OP_SRL: begin
        step1 = {1'b0,  acc_q[WIDTH-1:1]};
        step2 = {2'b00, acc_q[WIDTH-1:2]};
      end
      OP_SRA: begin
        step1 = {acc_q[WIDTH-1],      acc_q[WIDTH-1:1]};
        step2 = {{2{acc_q[WIDTH-1]}}, acc_q[WIDTH-1:2]};
      end
      default: begin
        step1 = {acc_q[WIDTH-2:0], acc_q[WIDTH-1]};
        step2 = {acc_q[WIDTH-3:0], acc_q[WIDTH-1:WIDTH-2]};
      end
    endcase
  end

  assign use2 = (cnt_q >= SHAMT_W'(2));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = in_data;
          cnt_d   = shamt;
          op_d    = op;
          state_d = (shamt != '0) ? S_SHIFT : S_DONE;
        end
      end
      S_SHIFT: begin
        acc_d   = use2 ? step2 : step1;
        cnt_d   = use2 ? (cnt_q - SHAMT_W'(2)) : (cnt_q - SHAMT_W'(1));
        state_d = (cnt_d == '0) ? S_DONE : S_SHIFT;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q != S_IDLE);
    done     = (state_q == S_DONE);
    out_data = acc_q;
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: latency, results, start gating and
// mid-operation reset, with hand-computed expectations.
module tb_shift_sequencer;

  logic        clk, rst, start;
  logic [1:0]  op;
  logic [31:0] in_data;
  logic [4:0]  shamt;
  logic        busy, done;
  logic [31:0] out_data;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] SLL = 2'b00, SRL = 2'b01, SRA = 2'b10, ROTL = 2'b11;

  shift_sequencer #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .in_data(in_data),
    .shamt(shamt), .busy(busy), .done(done), .out_data(out_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Accept one operation, then check busy/done cycle by cycle and the held result.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] d,
                        input logic [4:0] n, input logic [31:0] exp);
    int k;
    k = (int'(n) + 1) / 2;
    @(negedge clk);
    op = o; in_data = d; shamt = n; start = 1'b1;
    @(posedge clk);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      start = 1'b0; in_data = 32'hFFFF_FFFF; shamt = 5'd31; op = ~o;
      chk({tag, ":busy_run"}, 32'(busy), 32'd1);
      chk({tag, ":done_run"}, 32'(done), 32'd0);
      @(posedge clk);
    end
    @(negedge clk);
    start = 1'b0;
    chk({tag, ":done"}, 32'(done), 32'd1);
    chk({tag, ":busy_done"}, 32'(busy), 32'd1);
    chk({tag, ":result"}, out_data, exp);
    @(posedge clk);
    @(negedge clk);
    chk({tag, ":busy_after"}, 32'(busy), 32'd0);
    chk({tag, ":done_after"}, 32'(done), 32'd0);
    chk({tag, ":held"}, out_data, exp);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = SLL; in_data = '0; shamt = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset:busy", 32'(busy), 32'd0);
    chk("reset:done", 32'(done), 32'd0);
    chk("reset:out", out_data, 32'd0);
    rst = 1'b0;

    run_op("sll5",    SLL,  32'h0000_0001, 5'd5,  32'h0000_0020);
    run_op("sra31",   SRA,  32'h8000_0000, 5'd31, 32'hFFFF_FFFF);
    run_op("srl31",   SRL,  32'h8000_0000, 5'd31, 32'h0000_0001);
    run_op("rotl1",   ROTL, 32'h8000_0001, 5'd1,  32'h0000_0003);
    run_op("rotl4",   ROTL, 32'h1234_5678, 5'd4,  32'h2345_6781);
    run_op("zero",    SRA,  32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF);
    run_op("sra3pos", SRA,  32'h4000_0000, 5'd3,  32'h0800_0000);
    run_op("srl7",    SRL,  32'hF000_0000, 5'd7,  32'h01E0_0000);
    run_op("rotl31",  ROTL, 32'h0000_0001, 5'd31, 32'h8000_0000);
    run_op("sll31",   SLL,  32'hFFFF_FFFF, 5'd31, 32'h8000_0000);

    // Operand/start churn while busy must not disturb SLL 1 by 8.
    @(negedge clk);
    op = SLL; in_data = 32'h1; shamt = 5'd8; start = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = (i % 2 == 0); in_data = 32'hA5A5_0000 + 32'(i); op = ROTL; shamt = 5'(i + 3);
      chk("churn:busy", 32'(busy), 32'd1);
      chk("churn:done", 32'(done), 32'd0);
      @(posedge clk);
    end
    @(negedge clk);
    chk("churn:done_pulse", 32'(done), 32'd1);
    chk("churn:result", out_data, 32'h0000_0100);
    op = ROTL; in_data = 32'h1234_5678; shamt = 5'd4; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("held_start:idle_busy", 32'(busy), 32'd0);
    chk("held_start:idle_done", 32'(done), 32'd0);
    chk("held_start:idle_out", out_data, 32'h0000_0100);
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("held_start:busy", 32'(busy), 32'd1);
      chk("held_start:done_run", 32'(done), 32'd0);
      @(posedge clk);
    end
    @(negedge clk);
    start = 1'b0;
    chk("held_start:done", 32'(done), 32'd1);
    chk("held_start:result", out_data, 32'h2345_6781);
    @(posedge clk);
    @(negedge clk);
    chk("held_start:busy_after", 32'(busy), 32'd0);

    // Reset in the middle of a shamt=20 operation.
    op = SLL; in_data = 32'hFFFF_FFFF; shamt = 5'd20; start = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'b0;
      chk("abort:busy_pre", 32'(busy), 32'd1);
      @(posedge clk);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("abort:busy", 32'(busy), 32'd0);
    chk("abort:done", 32'(done), 32'd0);
    chk("abort:out", out_data, 32'd0);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("abort:no_done", 32'(done), 32'd0);
      chk("abort:idle", 32'(busy), 32'd0);
    end
    run_op("after_abort", SLL, 32'h0000_0003, 5'd2, 32'h0000_000C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multicycle shift unit for the CPU datapath that performs SLL, SRL, SRA and rotate-left by a 5-bit amount. It needs no 32-way barrel shifter; it iterates a fixed shift-by-2 stage (with a shift-by-1 fallback) under a small FSM. It sits beside the ALU and is driven by the multicycle control unit through a start/busy/done handshake. Result is registered and held until the next accepted start.

## Interface
- WIDTH, 32, data width (only 32 is supported)
- SHAMT_W, 5, shift-amount width; must satisfy 2^SHAMT_W = WIDTH

- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROTL
- in_data  input  WIDTH  operand; captured with start
- shamt  input  SHAMT_W  shift amount 0..31; captured with start
- busy  output  1  high while state is SHIFT or DONE
- done  output  1  one-cycle pulse; out_data is valid in this cycle
- out_data  output  WIDTH  result register

## Operation
- State machine states: IDLE, SHIFT, DONE.
- Internal registers: acc (WIDTH), cnt (SHAMT_W), op_r (2).
- out_data is driven directly from acc.
- Reset: state IDLE, acc 0, cnt 0, op_r 00, busy 0, done 0, out_data 0.
- Reset takes priority over all other activity. A reset mid-operation aborts the operation with no done pulse, and all outputs are 0 in the following cycle.
- **IDLE**
  - start=1: acc←in_data, cnt←shamt, op_r←op.
  - Next state is SHIFT if shamt≠0, otherwise DONE.
  - start=0: hold state; acc (and so out_data) holds its last value.
- **SHIFT**, one step per cycle:
  - If cnt≥2, shift acc by 2 and set cnt←cnt−2.
  - Otherwise shift acc by 1 and set cnt←cnt−1.
  - When the updated cnt is 0, go to DONE; otherwise stay in SHIFT.
- Step rules, for k = 1 or 2:
  - SLL: acc←{acc[W−1−k:0], k zeros}.
  - SRL: acc←{k zeros, acc[W−1:k]}.
  - SRA: acc←{k copies of acc[W−1], acc[W−1:k]}.
  - ROTL: acc←{acc[W−1−k:0], acc[W−1:W−k]}.
- **DONE**: done=1 for exactly this cycle. Next state is IDLE unconditionally.
- start is ignored while busy=1, including in the DONE cycle. A start held high across DONE is accepted on the first IDLE cycle after it.
- op, in_data and shamt are don't-care except in the cycle start is accepted. Changes to them mid-operation have no effect.
- Outside the shifting states, out_data changes only when a start is accepted. After a start is accepted, acc is only meaningful while done=1 and afterwards until the next accepted start.

## Timing
- Let E0 be the edge that accepts start, n = shamt, and k = ceil(n/2).
- Shift steps occur at edges E1..Ek. done is high in the cycle after edge Ek, where k=0 means the cycle after E0.
- busy is high from after E0 through the done cycle inclusive, for k+1 cycles. It drops after edge E(k+1).
- Minimum start-to-start spacing is k+2 cycles.
- Worst case is n=31: k=16, with done 16 edges after acceptance.
- A 2-bit step happens whenever cnt≥2. The single 1-bit step occurs only as the final step, when n is odd.

## Test plan
- SLL, in_data=0x00000001, shamt=5, pulse start → busy rises; done high in cycle after E3; out_data=0x00000020; busy low after E4.
- SRA, in_data=0x80000000, shamt=31 → done after E16; out_data=0xFFFFFFFF. Same operand with SRL → 0x00000001.
- ROTL, in_data=0x80000001, shamt=1 → done after E1; out_data=0x00000003. ROTL 0x12345678 by 4 → 0x23456781.
- shamt=0, any op, in_data=0xDEADBEEF → no SHIFT state; done in cycle after E0; out_data=0xDEADBEEF.
- Start SLL 1 by 8. Mid-run, change in_data, op and shamt, and pulse start repeatedly → result remains 0x00000100 with a single done pulse. start held through DONE → second operation accepted in the following IDLE cycle.
- Assert rst for one cycle during SHIFT of a shamt=20 operation → no done pulse; busy=0 and out_data=0 in the next cycle; a fresh start then completes normally.
